sram_port_arbiter: RTL and testbench

- Shares the single-port data SRAM between the processor core load/store path and an external host/debug port.
- Sits between the core's SRAM address/data multiplexing and the SRAM instance. It drives the SRAM_R/SRAM_W strobes, and stalls the core's timing generator while the host owns the memory.
- Core has default priority. A starvation counter guarantees host progress. A burst counter bounds host ownership.

---
 rtl/sram_port_arbiter.sv | 113 +++++++++++
 tb/tb_sram_port_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Arbitrates the single-port data SRAM between the core load/store path and the host/debug port.
// The core wins by default; a starvation counter forces host progress and a burst counter bounds host ownership.
module sram_port_arbiter #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int STARVE_LIMIT   = 4,
  parameter int HOST_BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              SRAM_R,
  output logic              SRAM_W,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [1:0]        owner
);

  // Handshake: a requester holds req/we/addr/wdata until the cycle it sees
  // its grant (host_gnt=1, or core_req=1 with core_stall=0); that cycle is the access.
  typedef enum logic [1:0] {IDLE = 2'd0, CORE = 2'd1, HOST = 2'd2} state_t;

  localparam logic [3:0] STARVE_L = 4'(STARVE_LIMIT);
  localparam logic [3:0] BURST_L  = 4'(HOST_BURST_MAX);

  state_t     state_q, state_d;
  logic [3:0] host_wait_q, host_wait_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;
  logic       core_rvalid_q, host_rvalid_q;
  logic [1:0] owner_q;
  logic       gnt_core, gnt_host;

  always_comb begin
    gnt_core    = 1'b0;
    gnt_host    = 1'b0;
    state_d     = IDLE;
    burst_cnt_d = 4'd0;
    if (state_q == HOST && host_req && burst_cnt_q < BURST_L) begin
      gnt_host    = 1'b1;
      state_d     = HOST;
      burst_cnt_d = burst_cnt_q + 4'd1;
    end else if (state_q == HOST && core_req) begin
      // One core access is owed after every host burst.
      gnt_core = 1'b1;
      state_d  = CORE;
    end else if (host_req && (!core_req || host_wait_q >= STARVE_L)) begin
      gnt_host    = 1'b1;
      state_d     = HOST;
      burst_cnt_d = 4'd1;
    end else if (core_req) begin
      gnt_core = 1'b1;
      state_d  = CORE;
    end
    if (!Reset) begin
      gnt_core = 1'b0;
      gnt_host = 1'b0;
    end
  end

  always_comb begin
    host_wait_d = host_wait_q;
    if (gnt_host) begin
      host_wait_d = 4'd0;
    end else if (host_req && host_wait_q < STARVE_L) begin
      host_wait_d = host_wait_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= IDLE;
      host_wait_q   <= 4'd0;
      burst_cnt_q   <= 4'd0;
      core_rvalid_q <= 1'b0;
      host_rvalid_q <= 1'b0;
      owner_q       <= 2'b00;
    end else begin
      state_q       <= state_d;
      host_wait_q   <= host_wait_d;
      burst_cnt_q   <= burst_cnt_d;
      core_rvalid_q <= gnt_core & ~core_we;
      host_rvalid_q <= gnt_host & ~host_we;
      owner_q       <= {gnt_host, gnt_core};
    end
  end

  assign core_stall  = core_req & ~gnt_core & Reset;
  assign host_gnt    = gnt_host;
  assign sram_addr   = gnt_host ? host_addr  : (gnt_core ? core_addr  : '0);
  assign sram_wdata  = gnt_host ? host_wdata : (gnt_core ? core_wdata : '0);
  assign SRAM_W      = (gnt_host & host_we) | (gnt_core & core_we);
  assign SRAM_R      = (gnt_host & ~host_we) | (gnt_core & ~core_we);
  assign core_rvalid = core_rvalid_q;
  assign host_rvalid = host_rvalid_q;
  assign core_rdata  = core_rvalid_q ? sram_rdata : '0;
  assign host_rdata  = host_rvalid_q ? sram_rdata : '0;
  assign owner       = owner_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter with a behavioural SRAM and per-port read-data scoreboards.
module tb_sram_port_arbiter;

  logic       clk = 1'b0;
  logic       Reset = 1'b0;
  logic       core_req = 1'b0, core_we = 1'b0;
  logic [7:0] core_addr = '0, core_wdata = '0;
  logic       host_req = 1'b0, host_we = 1'b0;
  logic [7:0] host_addr = '0, host_wdata = '0;
  logic       core_stall, core_rvalid, host_gnt, host_rvalid, SRAM_R, SRAM_W;
  logic [7:0] core_rdata, host_rdata, sram_addr, sram_wdata;
  logic [7:0] sram_rdata = '0;
  logic [1:0] owner;

  logic [7:0] mem [256];
  logic [7:0] exp_mem [256];
  logic [7:0] core_exp_q [$];
  logic [7:0] host_exp_q [$];
  int n_checks = 0;
  int n_err = 0;

  sram_port_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(4), .HOST_BURST_MAX(4)) dut (
    .clk(clk), .Reset(Reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .SRAM_R(SRAM_R), .SRAM_W(SRAM_W),
    .sram_rdata(sram_rdata), .owner(owner)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // behavioural SRAM: write in the strobe cycle, read data the cycle after
  always @(posedge clk) begin
    if (SRAM_W) mem[sram_addr] <= sram_wdata;
    if (SRAM_R) sram_rdata <= mem[sram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: pop expected read data whenever a port reports rvalid
  always @(negedge clk) begin
    if (Reset) begin
      if (core_rvalid) begin
        if (core_exp_q.size() == 0) chk("core_rvalid_unexpected", 1, 0);
        else chk("core_rdata", core_rdata, core_exp_q.pop_front());
      end else if (core_rdata != 8'h00) chk("core_rdata_idle", core_rdata, 0);
      if (host_rvalid) begin
        if (host_exp_q.size() == 0) chk("host_rvalid_unexpected", 1, 0);
        else chk("host_rdata", host_rdata, host_exp_q.pop_front());
      end else if (host_rdata != 8'h00) chk("host_rdata_idle", host_rdata, 0);
    end
  end

  task automatic drive(input logic cr, input logic cwe, input logic [7:0] ca, input logic [7:0] cd,
                       input logic hr, input logic hwe, input logic [7:0] ha, input logic [7:0] hd);
    core_req = cr; core_we = cwe; core_addr = ca; core_wdata = cd;
    host_req = hr; host_we = hwe; host_addr = ha; host_wdata = hd;
  endtask

  // One cycle with the expected grant; checks strobes/mux, records expectations, checks owner after the edge.
  task automatic step(input logic cg, input logic hg, input string tag);
    logic [7:0] ea;
    logic       er, ew;
    @(negedge clk);
    ea = hg ? host_addr : (cg ? core_addr : 8'h00);
    er = (hg & ~host_we) | (cg & ~core_we);
    ew = (hg & host_we) | (cg & core_we);
    chk({tag, "_core_stall"}, core_stall, core_req & ~cg);
    chk({tag, "_host_gnt"}, host_gnt, hg);
    chk({tag, "_sram_addr"}, sram_addr, ea);
    chk({tag, "_SRAM_R"}, SRAM_R, er);
    chk({tag, "_SRAM_W"}, SRAM_W, ew);
    if (ew) chk({tag, "_sram_wdata"}, sram_wdata, hg ? host_wdata : core_wdata);
    #1;
    if (hg && !host_we) host_exp_q.push_back(exp_mem[host_addr]);
    if (hg && host_we) exp_mem[host_addr] = host_wdata;
    if (cg && !core_we) core_exp_q.push_back(exp_mem[core_addr]);
    if (cg && core_we) exp_mem[core_addr] = core_wdata;
    @(posedge clk);
    #1;
    chk({tag, "_owner"}, owner, {hg, cg});
  endtask

  initial begin
    int r;
    logic we;
    logic [7:0] a, d;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom_range(0, 255));
      exp_mem[i] = mem[i];
    end
    mem[8'h10] = 8'h5A; exp_mem[8'h10] = 8'h5A;
    mem[8'h01] = 8'hC3; exp_mem[8'h01] = 8'hC3;
    mem[8'h02] = 8'h3C; exp_mem[8'h02] = 8'h3C;
    mem[8'h40] = 8'h77; exp_mem[8'h40] = 8'h77;

    // 1: reset held with a pending core read
    drive(1, 0, 8'h10, 0, 0, 0, 0, 0);
    repeat (2) begin
      @(negedge clk);
      chk("t1_rst_SRAM_R", SRAM_R, 0);
      chk("t1_rst_core_stall", core_stall, 0);
      chk("t1_rst_host_gnt", host_gnt, 0);
      chk("t1_rst_owner", owner, 0);
      chk("t1_rst_core_rvalid", core_rvalid, 0);
    end
    @(posedge clk); #1;
    Reset = 1'b1;
    step(1, 0, "t1_grant");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, "t1_ret");

    // 2: core write then host read of the same word
    drive(1, 1, 8'h20, 8'h33, 0, 0, 0, 0);
    step(1, 0, "t2_cwr");
    drive(0, 0, 0, 0, 1, 0, 8'h20, 0);
    step(0, 1, "t2_hrd");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, "t2_idle");

    // 3: both requesting continuously: 4 core, 4 host, repeating
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 8'h01, 0, 1, 0, 8'h02, 0);
      step((i % 8) < 4, (i % 8) >= 4, "t3_contend");
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, "t3_gap");

    // 4: host burst cut short by host_req drop, then a fresh full burst
    drive(0, 0, 0, 0, 1, 0, 8'h02, 0);
    step(0, 1, "t4_h1");
    drive(1, 0, 8'h01, 0, 1, 0, 8'h02, 0);
    step(0, 1, "t4_h2");
    drive(1, 0, 8'h01, 0, 0, 0, 0, 0);
    step(1, 0, "t4_core");
    drive(0, 0, 0, 0, 1, 0, 8'h02, 0);
    step(0, 1, "t4_b1");
    drive(1, 0, 8'h01, 0, 1, 0, 8'h02, 0);
    for (int i = 0; i < 3; i++) step(0, 1, "t4_burst");
    step(1, 0, "t4_after_max");

    // 5: reset lands while a host read is in flight
    drive(0, 0, 0, 0, 1, 0, 8'h40, 0);
    @(negedge clk);
    chk("t5_host_gnt", host_gnt, 1);
    #2 Reset = 1'b0;
    #1;
    chk("t5_async_host_gnt", host_gnt, 0);
    chk("t5_async_SRAM_R", SRAM_R, 0);
    chk("t5_async_sram_addr", sram_addr, 0);
    chk("t5_async_owner", owner, 0);
    chk("t5_async_host_rvalid", host_rvalid, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_rst_host_rvalid", host_rvalid, 0);
    Reset = 1'b1;
    @(negedge clk);
    chk("t5_post_host_rvalid", host_rvalid, 0);
    chk("t5_post_host_rdata", host_rdata, 0);
    @(posedge clk); #1;

    // 6: alternating single-cycle core/host reads
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        drive(1, 0, 8'h01, 0, 0, 0, 0, 0);
        step(1, 0, "t6_core");
      end else begin
        drive(0, 0, 0, 0, 1, 0, 8'h02, 0);
        step(0, 1, "t6_host");
      end
    end

    // random single-requester traffic
    for (int i = 0; i < 30; i++) begin
      r  = $urandom_range(0, 2);
      we = 1'($urandom_range(0, 1));
      a  = 8'h80 + 8'($urandom_range(0, 15));
      d  = 8'($urandom_range(0, 255));
      if (r == 1) begin
        drive(1, we, a, d, 0, 0, 0, 0);
        step(1, 0, "rnd_core");
      end else if (r == 2) begin
        drive(0, 0, 0, 0, 1, we, a, d);
        step(0, 1, "rnd_host");
      end else begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, "rnd_idle");
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("core_q_drained", core_exp_q.size(), 0);
    chk("host_q_drained", host_exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
